// File: rtl/wb_uart_loader.sv
// UART (8N1) boot loader: parses a framed, checksummed program image and writes it
// word by word into RAM over Wishbone, holding the J1 core in reset until it verifies.
module wb_uart_loader #(
    parameter int          CLKS_PER_BIT = 217,
    parameter logic [15:0] BASE_ADR     = 16'h0,
    parameter int          MAX_WORDS    = 16384,
    parameter int          TIMEOUT_CLKS = 2500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_i,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [15:0] adr_o,
    output logic [15:0] dat_o,
    output logic        cpu_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [15:0] words_o
);
    localparam int                CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int                TMO_W     = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [31:0]       MAX_LEN   = 32'(MAX_WORDS);
    localparam logic [15:0]       BASE_WORD = {BASE_ADR[15:1], 1'b0};
    localparam logic [7:0]        SYNC_BYTE = 8'hA5;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [3:0] {
        S_IDLE, S_LEN_H, S_LEN_L, S_DAT_H, S_DAT_L, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    logic             r_rx_p0, r_rx_p1, r_rx_p2;
    rx_state_t        r_rx_state;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic             r_rx_vld;
    logic             r_rx_ferr;

    state_t           r_state;
    logic             r_wr;
    logic [15:0]      r_adr;
    logic [15:0]      r_dat;
    logic             r_cpu_rst;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [15:0]      r_words;
    logic [15:0]      r_len;
    logic [7:0]       r_sum;
    logic [TMO_W-1:0] r_tmo;

    logic [7:0]       w_byte;
    logic [15:0]      w_len;
    logic [15:0]      w_words_nxt;
    logic             w_timed;
    logic             w_abort;

    // Stage p0/p1: metastability synchroniser; p2 holds the previous level for edge detection
    always_ff @(posedge clk) begin
        r_rx_p0   <= rx_i;
        r_rx_p1   <= r_rx_p0;
        r_rx_p2   <= r_rx_p1;
        r_rx_vld  <= 1'b0;
        r_rx_ferr <= 1'b0;
        if (rst) begin
            r_rx_p0    <= 1'b1;
            r_rx_p1    <= 1'b1;
            r_rx_p2    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
        end else begin
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_rx_p2 && !r_rx_p1)
                        r_rx_state <= RX_START;
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_p1 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_p1, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7)
                            r_rx_state <= RX_STOP;
                        else
                            r_rx_bit <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                        if (r_rx_p1)
                            r_rx_vld <= 1'b1;
                        else
                            r_rx_ferr <= 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign w_byte      = r_rx_shift;
    assign w_len       = {r_len[15:8], w_byte};
    assign w_words_nxt = r_words + 16'd1;
    assign w_timed     = r_state inside {S_LEN_H, S_LEN_L, S_DAT_H, S_DAT_L, S_WRITE, S_CSUM};
    assign w_abort     = (r_rx_ferr && r_state != S_DONE && r_state != S_ERR)
                       || (w_timed && !r_rx_vld && r_tmo == TMO_LAST);

    // Frame stage: consumes one received byte per rx_valid pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wr      <= 1'b0;
            r_adr     <= BASE_WORD;
            r_dat     <= '0;
            r_cpu_rst <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_words   <= '0;
            r_len     <= '0;
            r_sum     <= '0;
            r_tmo     <= '0;
        end else begin
            r_tmo <= (w_timed && !r_rx_vld) ? r_tmo + TMO_W'(1) : '0;
            case (r_state)
                S_IDLE: begin
                    if (r_rx_vld && w_byte == SYNC_BYTE) begin
                        r_state <= S_LEN_H;
                        r_err   <= 1'b0;
                        r_words <= '0;
                        r_sum   <= '0;
                        r_adr   <= BASE_WORD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LEN_H: begin
                    if (r_rx_vld) begin
                        r_len[15:8] <= w_byte;
                        r_state     <= S_LEN_L;
                    end
                end
                S_LEN_L: begin
                    if (r_rx_vld) begin
                        r_len[7:0] <= w_byte;
                        if (w_len == 16'd0) begin
                            r_state <= S_CSUM;
                        end else if ({16'd0, w_len} > MAX_LEN) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= S_DAT_H;
                        end
                    end
                end
                S_DAT_H: begin
                    if (r_rx_vld) begin
                        r_dat[15:8] <= w_byte;
                        r_sum       <= r_sum + w_byte;
                        r_state     <= S_DAT_L;
                    end
                end
                S_DAT_L: begin
                    if (r_rx_vld) begin
                        r_dat[7:0] <= w_byte;
                        r_sum      <= r_sum + w_byte;
                        r_wr       <= 1'b1;
                        r_state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // RAM has no ack: the write commits on this edge unconditionally
                    r_wr    <= 1'b0;
                    r_adr   <= r_adr + 16'd2;
                    r_words <= w_words_nxt;
                    r_state <= (w_words_nxt == r_len) ? S_CSUM : S_DAT_H;
                end
                S_CSUM: begin
                    if (r_rx_vld) begin
                        if (w_byte == r_sum) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b0;
                            r_busy    <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_DONE: r_state <= S_DONE;
                S_ERR: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
            if (w_abort) begin
                r_state <= S_ERR;
                r_err   <= 1'b1;
                r_busy  <= 1'b1;
            end
        end
    end

    assign cyc_o     = r_wr;
    assign stb_o     = r_wr;
    assign we_o      = r_wr;
    assign adr_o     = r_adr;
    assign dat_o     = r_dat;
    assign cpu_rst_o = r_cpu_rst;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign words_o   = r_words;
endmodule
